// File: rtl/state_pkg.sv
// Animation state seen by the player sprite drawer, plus the jump phase and walk direction.
package state_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RIGHT1,
        LEFT1,
        RIGHT2,
        LEFT2
    } State;

    typedef enum logic [1:0] {
        GROUND,
        RISING,
        FALLING
    } jump_state_t;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_RIGHT,
        DIR_LEFT
    } dir_t;

endpackage

// File: rtl/vga_pkg.sv
// VGA geometry shared by the drawing stages and the per-frame controllers.
package vga_pkg;

    localparam int unsigned SCREEN_W = 800;
    localparam int unsigned SPRITE_W = 40;

endpackage

// File: rtl/frame_tick_gen.sv
// Rising-edge detector on vblnk; frame_tick is a registered one-cycle pulse per frame.
module frame_tick_gen (
    input  logic clk,
    input  logic rst,
    input  logic vblnk,
    output logic frame_tick
);

    logic vblnk_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            vblnk_d    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            vblnk_d    <= vblnk;
            frame_tick <= vblnk & ~vblnk_d;
        end
    end

endmodule

// File: rtl/player_motion_ctl.sv
// Per-frame player controller: turns key levels into sprite position and animation state,
// updating only once per frame so the drawer never sees a mid-frame change.
module player_motion_ctl
    import state_pkg::*;
#(
    parameter int unsigned STEP        = 4,
    parameter int unsigned X_MIN       = 0,
    parameter int unsigned X_MAX       = vga_pkg::SCREEN_W - vga_pkg::SPRITE_W,
    parameter int unsigned X_START     = 380,
    parameter int unsigned Y_GROUND    = 100,
    parameter int unsigned JUMP_V      = 12,
    parameter int unsigned GRAVITY     = 1,
    parameter int unsigned ANIM_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic        move_left,
    input  logic        move_right,
    input  logic        jump,
    output logic [11:0] xpos_player1,
    output logic [11:0] ypos_player1,
    output State        state,
    output logic        frame_tick
);

    localparam int unsigned AW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

    logic [11:0]   x_q, x_d, y_q, y_d, vel_q, vel_d;
    logic [AW-1:0] anim_cnt_q, anim_cnt_d;
    logic          phase_q, phase_d, armed_q, armed_d;
    jump_state_t   jump_q, jump_d;
    dir_t          dir_q, dir_d, dir_now;
    State          state_q, state_d;
    logic [12:0]   x_sum, x_dif, y_sub, y_add;

    frame_tick_gen u_frame_tick_gen (
        .clk        (clk),
        .rst        (rst),
        .vblnk      (vblnk),
        .frame_tick (frame_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q        <= 12'(X_START);
            y_q        <= 12'(Y_GROUND);
            vel_q      <= '0;
            jump_q     <= GROUND;
            anim_cnt_q <= '0;
            phase_q    <= 1'b0;
            armed_q    <= 1'b1;
            dir_q      <= DIR_NONE;
            state_q    <= IDLE;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            vel_q      <= vel_d;
            jump_q     <= jump_d;
            anim_cnt_q <= anim_cnt_d;
            phase_q    <= phase_d;
            armed_q    <= armed_d;
            dir_q      <= dir_d;
            state_q    <= state_d;
        end
    end

    // Vertical motion: jump FSM next state, velocity and height.
    always_comb begin
        jump_d  = jump_q;
        vel_d   = vel_q;
        y_d     = y_q;
        armed_d = armed_q;
        y_sub   = {1'b0, y_q} - {1'b0, vel_q};
        y_add   = '0;
        if (frame_tick) begin
            if (!jump) begin
                armed_d = 1'b1;
            end
            unique case (jump_q)
                GROUND: begin
                    if (jump && armed_q) begin
                        vel_d   = 12'(JUMP_V);
                        armed_d = 1'b0;
                        jump_d  = RISING;
                    end
                end
                RISING: begin
                    y_d = y_sub[12] ? 12'd0 : y_sub[11:0];
                    if (vel_q <= 12'(GRAVITY)) begin
                        vel_d  = '0;
                        jump_d = FALLING;
                    end else begin
                        vel_d = vel_q - 12'(GRAVITY);
                    end
                end
                FALLING: begin
                    vel_d = vel_q + 12'(GRAVITY);
                    y_add = {1'b0, y_q} + {1'b0, vel_d};
                    if (y_add >= 13'(Y_GROUND)) begin
                        y_d    = 12'(Y_GROUND);
                        vel_d  = '0;
                        jump_d = GROUND;
                    end else begin
                        y_d = y_add[11:0];
                    end
                end
                default: jump_d = GROUND;
            endcase
        end
    end

    // Horizontal motion and walk animation.
    always_comb begin
        x_d        = x_q;
        anim_cnt_d = anim_cnt_q;
        phase_d    = phase_q;
        dir_d      = dir_q;
        state_d    = state_q;
        x_sum      = {1'b0, x_q} + 13'(STEP);
        x_dif      = {1'b0, x_q} - 13'(STEP);
        if (move_right && !move_left) begin
            dir_now = DIR_RIGHT;
        end else if (move_left && !move_right) begin
            dir_now = DIR_LEFT;
        end else begin
            dir_now = DIR_NONE;
        end
        if (frame_tick) begin
            if (dir_now == DIR_RIGHT) begin
                x_d = (x_sum > 13'(X_MAX)) ? 12'(X_MAX) : x_sum[11:0];
            end else if (dir_now == DIR_LEFT) begin
                x_d = (x_dif[12] || x_dif < 13'(X_MIN)) ? 12'(X_MIN) : x_dif[11:0];
            end
            if (dir_now == DIR_NONE || dir_now != dir_q) begin
                anim_cnt_d = '0;
                phase_d    = 1'b0;
            end else if (anim_cnt_q == AW'(ANIM_FRAMES - 1)) begin
                anim_cnt_d = '0;
                phase_d    = ~phase_q;
            end else begin
                anim_cnt_d = anim_cnt_q + AW'(1);
            end
            dir_d = dir_now;
            unique case (dir_now)
                DIR_RIGHT: state_d = phase_d ? RIGHT2 : RIGHT1;
                DIR_LEFT:  state_d = phase_d ? LEFT2 : LEFT1;
                default:   state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        xpos_player1 = x_q;
        ypos_player1 = y_q;
        state        = state_q;
    end

endmodule

// File: tb/tb_player_motion_ctl.sv
// Directed + randomized bench for player_motion_ctl against a per-frame behavioural model.
module tb_player_motion_ctl;
    import state_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vblnk = 1'b0;
    logic        move_left = 1'b0;
    logic        move_right = 1'b0;
    logic        jump = 1'b0;
    logic [11:0] xpos, ypos;
    State        state;
    logic        frame_tick;

    int tests = 0;
    int fails = 0;

    // Behavioural model: position, upward velocity, airborne flag, animation bookkeeping.
    int m_x, m_y, m_vel, m_last, m_cnt;
    bit m_air, m_phase, m_armed;

    always #5 clk = ~clk;

    player_motion_ctl dut (
        .clk          (clk),
        .rst          (rst),
        .vblnk        (vblnk),
        .move_left    (move_left),
        .move_right   (move_right),
        .jump         (jump),
        .xpos_player1 (xpos),
        .ypos_player1 (ypos),
        .state        (state),
        .frame_tick   (frame_tick)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic State exp_state();
        if (m_last == 1) return m_phase ? RIGHT2 : RIGHT1;
        if (m_last == -1) return m_phase ? LEFT2 : LEFT1;
        return IDLE;
    endfunction

    task automatic check_outputs(input string tag);
        check_val({tag, ".x"}, int'(xpos), m_x);
        check_val({tag, ".y"}, int'(ypos), m_y);
        check_val({tag, ".state"}, int'(state), int'(exp_state()));
    endtask

    task automatic model_reset();
        m_x = 380; m_y = 100; m_vel = 0; m_air = 0;
        m_last = 0; m_cnt = 0; m_phase = 0; m_armed = 1;
    endtask

    task automatic model_frame(input bit l, input bit r, input bit j);
        int d;
        d = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
        if (d == 1) m_x = (m_x + 4 > 760) ? 760 : m_x + 4;
        if (d == -1) m_x = (m_x - 4 < 0) ? 0 : m_x - 4;
        if (d == 0 || d != m_last) begin
            m_cnt = 0; m_phase = 0;
        end else if (m_cnt == 7) begin
            m_cnt = 0; m_phase = !m_phase;
        end else begin
            m_cnt++;
        end
        m_last = d;
        if (!j) m_armed = 1;
        if (!m_air) begin
            if (j && m_armed) begin
                m_air = 1; m_vel = 12; m_armed = 0;
            end
        end else if (m_vel > 0) begin
            m_y = (m_y - m_vel < 0) ? 0 : m_y - m_vel;
            m_vel--;
        end else begin
            m_vel--;
            m_y = m_y - m_vel;
            if (m_y >= 100) begin
                m_y = 100; m_vel = 0; m_air = 0;
            end
        end
    endtask

    // One video frame; entered and left #1 after a rising clock edge.
    task automatic frame(input bit l, input bit r, input bit j);
        move_left = l; move_right = r; jump = j;
        vblnk = 1'b1;
        @(posedge clk); #1;
        check_val("tick_high", int'(frame_tick), 1);
        check_outputs("pre_update");
        @(posedge clk); #1;
        model_frame(l, r, j);
        check_val("tick_low", int'(frame_tick), 0);
        check_outputs("post_update");
        repeat (2) @(posedge clk);
        #1 vblnk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int ticks;
        // 1: reset and idle frames
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        check_val("reset.tick", int'(frame_tick), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        repeat (3) frame(0, 0, 0);
        check_val("idle.x", int'(xpos), 380);

        // 2: walk right 10 frames
        for (int i = 1; i <= 10; i++) begin
            frame(0, 1, 0);
            check_val("walk.state", int'(state), (i <= 8) ? int'(RIGHT1) : int'(RIGHT2));
        end
        check_val("walk.x", int'(xpos), 420);

        // 3: right edge pinning, then both keys
        repeat (84) frame(0, 1, 0);
        check_val("edge.x756", int'(xpos), 756);
        repeat (3) begin
            frame(0, 1, 0);
            check_val("edge.pin", int'(xpos), 760);
        end
        frame(1, 1, 0);
        check_val("both.state", int'(state), int'(IDLE));
        check_val("both.x", int'(xpos), 760);

        // 4: jump held through landing, no retrigger until released
        frame(0, 0, 1);
        repeat (12) frame(0, 0, 1);
        check_val("jump.apex", int'(ypos), 22);
        repeat (12) frame(0, 0, 1);
        check_val("jump.land", int'(ypos), 100);
        repeat (3) frame(0, 0, 1);
        check_val("jump.noretrig", int'(ypos), 100);
        frame(0, 0, 0);

        // 5: reset at apex while walking left
        frame(1, 0, 1);
        repeat (12) frame(1, 0, 0);
        check_val("rst_apex.y", int'(ypos), 22);
        rst = 1'b0;
        @(posedge clk); #1;
        model_reset();
        check_outputs("mid_reset");
        rst = 1'b1;
        @(posedge clk); #1;
        frame(0, 0, 1);
        repeat (12) frame(0, 0, 0);
        check_val("rejump.apex", int'(ypos), 22);
        repeat (12) frame(0, 0, 0);
        check_val("rejump.land", int'(ypos), 100);

        // 6: long vblnk, keys churning after the tick
        move_left = 1'b0; move_right = 1'b1; jump = 1'b0;
        vblnk = 1'b1;
        @(posedge clk); #1;
        check_val("long.tick", int'(frame_tick), 1);
        @(posedge clk); #1;
        model_frame(0, 1, 0);
        check_outputs("long.update");
        ticks = 0;
        for (int i = 0; i < 40; i++) begin
            move_left = 1'($urandom); move_right = 1'($urandom); jump = 1'($urandom);
            @(posedge clk); #1;
            if (frame_tick) ticks++;
        end
        check_val("long.extra_ticks", ticks, 0);
        check_outputs("long.hold");
        vblnk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("long.after");

        // Randomized frames
        for (int i = 0; i < 120; i++) begin
            frame(1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/player_motion_ctl.md
Name: player_motion_ctl

Overview:
Per-frame controller that sequences the player sprite drawer. It turns keyboard direction and jump requests into the sprite drawer's position and animation-state inputs: xpos_player1, ypos_player1 and a state_pkg State. All updates happen once per video frame, on the rising edge of vblnk, so the drawer never sees a position change mid-frame. The block sits between the keyboard decoder and the player drawing stage, in the same pixel clock domain.

Parameters:
STEP, 4, horizontal pixels moved per frame while walking
X_MIN, 0, leftmost allowed xpos
X_MAX, 760, rightmost allowed xpos (800 minus the 40-pixel sprite width)
X_START, 380, xpos after reset
Y_GROUND, 100, ypos offset when standing; a jump decreases ypos
JUMP_V, 12, initial upward velocity in pixels per frame
GRAVITY, 1, velocity change per frame
ANIM_FRAMES, 8, frames per walk-animation phase

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous reset, active-low (the block is in reset while rst==0)
vblnk  in  1  vertical blank from the VGA timing chain
move_left  in  1  level, left key held
move_right  in  1  level, right key held
jump  in  1  level, jump key held
xpos_player1  out  12  sprite x offset
ypos_player1  out  12  sprite y offset
state  out  State  drawer animation state (IDLE, RIGHT1, LEFT1, RIGHT2, LEFT2)
frame_tick  out  1  one-cycle pulse, frame update strobe (debug/visibility)

Behaviour:
- Reset (rst==0 at a clk edge):
  - xpos=X_START, ypos=Y_GROUND, state=IDLE, frame_tick=0.
  - Internal: velocity=0, jump FSM=GROUND, anim_cnt=0, phase=0, jump_armed=1, vblnk_d=0.
  - Reset mid-jump or mid-walk aborts immediately to these values.
- Frame tick:
  - tick = vblnk & ~vblnk_d. frame_tick is registered, so it goes high 1 cycle after the vblnk rise.
  - move_left, move_right and jump are sampled only in the tick cycle.
  - Outputs update on the clk edge that ends the tick cycle, i.e. they are visible 2 cycles after the vblnk rise, and are stable at all other times.
- Horizontal movement, per tick:
  - right & ~left: x = min(x+STEP, X_MAX).
  - left & ~right: x = max(x-STEP, X_MIN), with the arithmetic done 13 bits wide so it cannot underflow.
  - Neither or both held: no motion.
- Walk animation, per tick:
  - No motion, or the direction differs from last tick: anim_cnt=0, phase=0.
  - Same direction as last tick: if anim_cnt==ANIM_FRAMES-1 then anim_cnt=0 and phase toggles; else anim_cnt+1.
  - Animation continues while pinned at X_MIN or X_MAX with the key held.
- state output:
  - No motion: IDLE.
  - Moving right: RIGHT1 if phase==0, RIGHT2 if phase==1.
  - Moving left: LEFT1 if phase==0, LEFT2 if phase==1.
- Jump FSM (GROUND, RISING, FALLING), per tick:
  - jump_armed is set at any tick where jump==0.
  - GROUND & jump & jump_armed: velocity=JUMP_V, jump_armed=0, go to RISING. ypos is unchanged this tick.
  - RISING: y = max(y-velocity, 0); velocity = velocity-GRAVITY; when the new velocity is 0, go to FALLING.
  - FALLING: velocity = velocity+GRAVITY; y = y+velocity; if the new y>=Y_GROUND then y=Y_GROUND, velocity=0, go to GROUND.
  - A held jump key never retriggers a jump; the key must be released first.
  - A jump press during RISING or FALLING is ignored.
  - Horizontal motion is allowed during a jump (air control).
  - state reflects horizontal motion only, also while airborne.

Decomposition:
- state_pkg: the existing State enum, plus a new jump_state_t (GROUND, RISING, FALLING).
- vga_pkg: sprite width 40 and screen width 800, from which the X_MAX default is derived.
- One sub-module, frame_tick_gen: edge detector on vblnk producing the registered one-cycle tick. Reused by future per-frame controllers.

Test Plan:
1. Reset, then release reset -> xpos=380, ypos=100, state=IDLE; outputs unchanged across 3 frames with no keys held.
2. move_right held for 10 frames from reset -> xpos=420; state=RIGHT1 after frames 1–8, RIGHT2 after frames 9–10.
3. Set xpos=756 via right presses, then hold right 3 frames -> xpos 760, 760, 760; state keeps animating. Hold left and right together -> state=IDLE, xpos unchanged.
4. Jump pulse from ground, no horizontal keys -> ypos drops over 12 rising frames to apex 22 (100-78), then returns over 12 falling frames to exactly 100; state IDLE throughout; jump held through landing causes no second jump until released.
5. Reset (rst=0) for one cycle at the jump apex while walking left -> next cycle xpos=380, ypos=100, state=IDLE; the following jump press starts a full jump.
6. vblnk held high for many cycles -> exactly one frame_tick and one position update; no key changes between ticks affect outputs.
